instr_ctrl: RTL
===============

# instr_ctrl

Multi-cycle fetch/decode/execute controller that sits directly upstream of the register-file/ALU datapath. It fetches 16-bit instructions over a request/acknowledge port and decodes them into the datapath controls (register addresses, immediate, immediate select, 5-bit ALU opcode, write enable). It latches the datapath flags and, when branching is compiled in, resolves conditional branches against them.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `Clk`, input, 1: single clock, rising edge.
- `Rst`, input, 1: synchronous, active-low reset.
- `instr_req`, output, 1: fetch request.
- `instr_addr`, output, 16: word address being fetched; equals `pc`.
- `instr_ack`, input, 1: `instr_data` valid this cycle.
- `instr_data`, input, 16: fetched instruction.
- `RdestRegLoc`, output, 4: destination/first operand register.
- `RsrcRegLoc`, output, 4: source register.
- `Imm`, output, 16: extended immediate.
- `Imm_s`, output, 1: 1 selects `Imm`, 0 selects the Rsrc register.
- `OpCode`, output, 5: ALU operation.
- `En`, output, 1: register-file write enable.
- `Flags`, input, 5: ALU flags {C,L,F,Z,N}, bits 4..0.
- `pc`, output, 16: current PC.
- `halted`, output, 1: HALT executed.

## Operation
- Format: [15:12] op, [11:8] Rdest/cond, [7:4] ext, [3:0] Rsrc; immediate forms use [7:0] imm8.
- op 0000 (register form):
  - OpCode={0,ext}, Imm_s=0.
  - ext 0000 is NOP (En=0).
- Immediate forms ANDI 0001, ORI 0010, XORI 0011, ADDI 0101, SUBI 1001, CMPI 1011, MOVI 1101:
  - OpCode={0,op}, Imm_s=1.
  - Imm is sign-extended for ADDI/SUBI/CMPI and zero-extended otherwise.
- LUI 1111: OpCode=0_1101 (MOV), Imm={imm8,8'h00}, Imm_s=1.
- Bcond 1100: cond=[11:8], disp=imm8. En=0.
- HALT 0100 with ext=0000: enters HALT.
- Every other encoding executes as NOP.
- En=0 for CMP, CMPI, NOP, Bcond and HALT.
- flags_q captures `Flags` for ADD/ADDI/SUB/SUBI/CMP/CMPI and holds otherwise. Reset value 5'b0.
- FSM: FETCH → DECODE → EXEC → FETCH; HALT is absorbing.
  - FETCH: instr_req=1. When instr_ack=1 at an edge, IR←instr_data and go to DECODE; otherwise stay.
  - DECODE: decoded controls are registered into the output registers; go to EXEC.
  - EXEC: En pulses for exactly this cycle. flags_q is updated at the closing edge. PC←PC+1, or PC+sext(disp) for a taken branch, mod 2^16. Go to FETCH, or HALT.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L&!Z
  - 1011 HS: L|Z
  - 1100 LT: !N&!Z
  - 1101 GE: N|Z
  - 1110: always
  - 1111: never
- Conditions are evaluated on flags_q.

## Timing
- Reset values (Rst=0 at an edge):
  - state=FETCH, pc=RESET_PC, IR=0
  - all control outputs 0: En, Imm_s, Imm, OpCode, RdestRegLoc, RsrcRegLoc
  - flags_q=0, halted=0
  - instr_req=1 from the first cycle after reset.
- Reset mid-fetch: abandons the fetch; a late instr_ack is ignored.
- Reset during EXEC: suppresses the PC and flag updates from that edge.
- Zero-wait memory (ack in the first FETCH cycle): 3 cycles per instruction. Each wait cycle adds 1.
- instr_ack is ignored outside FETCH.
- instr_addr is stable while instr_req=1.
- Control outputs are stable from DECODE exit through the end of EXEC, and held in FETCH. En is 0 everywhere except EXEC.
- Branch immediately after CMP: sees the flags captured at that CMP's EXEC edge.
- HALT: halted=1 from the cycle after EXEC; instr_req=0 and En=0 until reset.

## Configuration
- `INSTR_CTRL_BRANCH_EN`:
  - Defined: Bcond executes as specified and `cond_eval` is instantiated.
  - Undefined: op 1100 decodes as NOP, the PC always increments by 1, and no condition logic is built.

## Structure
- Shared package `instr_pkg`:
  - op and ext encodings
  - ALU opcode constants
  - condition-code constants
  - flag bit indices
  - FSM state enum {FETCH, DECODE, EXEC, HALT}
- Sub-module `cond_eval`: combinational; inputs are cond[3:0] and flags[4:0], output is taken.

## Test plan
- Reset → pc=0, instr_req=1 the next cycle; with zero-wait memory the first instr_addr is 0 and En=0 until the first EXEC.
- ADDI R3,#-2 (16'h53FE) → in EXEC: RdestRegLoc=3, Imm=16'hFFFE, Imm_s=1, OpCode=5'h05, En=1 for one cycle; pc increments to 1.
- LUI R1,#0xAB (16'hF1AB) → Imm=16'hAB00, OpCode=5'h0D, Imm_s=1. CMP R2,R4 (16'h02B4) → En=0, Flags captured into flags_q.
- With Flags Z=1 captured by CMP, BEQ disp=-4 (16'hC0FC) at pc=10 → next instr_addr=6. Same instruction with Z=0 → next instr_addr=11.
- instr_ack withheld for 3 cycles → instr_req and instr_addr held stable, no En pulse; the instruction completes in 6 cycles.
- HALT (16'h4000) → halted=1 and instr_req=0 thereafter; Rst low for one edge → pc=RESET_PC and normal fetch resumes.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared encodings, ALU opcodes, condition codes, flag indices, FSM states
// and the instruction decoder used by instr_ctrl.
package instr_pkg;

  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_HALT  = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hF;

  localparam logic [3:0] EXT_NOP = 4'h0;
  localparam logic [3:0] EXT_ADD = 4'h5;
  localparam logic [3:0] EXT_SUB = 4'h9;
  localparam logic [3:0] EXT_CMP = 4'hB;

  localparam logic [4:0] ALU_NOP = 5'h00;
  localparam logic [4:0] ALU_AND = 5'h01;
  localparam logic [4:0] ALU_OR  = 5'h02;
  localparam logic [4:0] ALU_XOR = 5'h03;
  localparam logic [4:0] ALU_ADD = 5'h05;
  localparam logic [4:0] ALU_SUB = 5'h09;
  localparam logic [4:0] ALU_CMP = 5'h0B;
  localparam logic [4:0] ALU_MOV = 5'h0D;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        imm_s;
    logic [4:0]  opcode;
    logic        en;
    logic        cap_flags;
    logic        is_bcond;
    logic        is_halt;
  } dec_t;

  // Anything not matched below leaves the all-zero controls, i.e. a NOP.
  function automatic dec_t decode_instr(input logic [15:0] ir);
    dec_t       d;
    logic [3:0] op;
    logic [3:0] ext;
    logic [7:0] imm8;
    op      = ir[15:12];
    ext     = ir[7:4];
    imm8    = ir[7:0];
    d       = '0;
    d.rdest = ir[11:8];
    d.rsrc  = ir[3:0];
    case (op)
      OP_REG: begin
        d.opcode    = {1'b0, ext};
        d.en        = (ext != EXT_NOP) && (ext != EXT_CMP);
        d.cap_flags = (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
        d.opcode = {1'b0, op};
        d.imm_s  = 1'b1;
        d.imm    = {8'h00, imm8};
        d.en     = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_CMPI: begin
        d.opcode    = {1'b0, op};
        d.imm_s     = 1'b1;
        d.imm       = {{8{imm8[7]}}, imm8};
        d.en        = (op != OP_CMPI);
        d.cap_flags = 1'b1;
      end
      OP_LUI: begin
        d.opcode = ALU_MOV;
        d.imm_s  = 1'b1;
        d.imm    = {imm8, 8'h00};
        d.en     = 1'b1;
      end
      OP_BCOND: d.is_bcond = 1'b1;
      OP_HALT:  d.is_halt  = (ext == EXT_NOP);
      default:  ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the latched
// {C,L,F,Z,N} flags to a taken bit. Purely combinational.
module cond_eval
  import instr_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic c_f, l_f, f_f, z_f, n_f;

  assign c_f = flags[FLAG_C];
  assign l_f = flags[FLAG_L];
  assign f_f = flags[FLAG_F];
  assign z_f = flags[FLAG_Z];
  assign n_f = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z_f;
      COND_NE: taken = !z_f;
      COND_CS: taken = c_f;
      COND_CC: taken = !c_f;
      COND_HI: taken = l_f;
      COND_LS: taken = !l_f;
      COND_GT: taken = n_f;
      COND_LE: taken = !n_f;
      COND_FS: taken = f_f;
      COND_FC: taken = !f_f;
      COND_LO: taken = !l_f && !z_f;
      COND_HS: taken = l_f || z_f;
      COND_LT: taken = !n_f && !z_f;
      COND_GE: taken = n_f || z_f;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_ctrl.sv
// Fetch/decode/execute controller driving the register-file/ALU datapath.
// Define INSTR_CTRL_BRANCH_EN to build conditional branches (cond_eval).
module instr_ctrl
  import instr_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        instr_req,
  output logic [15:0] instr_addr,
  input  logic        instr_ack,
  input  logic [15:0] instr_data,
  output logic [3:0]  RdestRegLoc,
  output logic [3:0]  RsrcRegLoc,
  output logic [15:0] Imm,
  output logic        Imm_s,
  output logic [4:0]  OpCode,
  output logic        En,
  input  logic [4:0]  Flags,
  output logic [15:0] pc,
  output logic        halted,
  output logic [1:0]  dbg_state,
  output logic [4:0]  dbg_flags
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic [4:0]  flags_q, flags_d;
  logic [3:0]  rdest_q, rdest_d;
  logic [3:0]  rsrc_q, rsrc_d;
  logic [15:0] imm_q, imm_d;
  logic        imm_s_q, imm_s_d;
  logic [4:0]  opcode_q, opcode_d;
  logic        en_q, en_d;
  logic        halted_q, halted_d;
  logic [15:0] next_pc;
  dec_t        dec;

  assign dec = decode_instr(ir_q);

`ifdef INSTR_CTRL_BRANCH_EN
  logic cond_taken;

  cond_eval u_cond_eval (
    .cond  (ir_q[11:8]),
    .flags (flags_q),
    .taken (cond_taken)
  );

  assign next_pc = (dec.is_bcond && cond_taken) ? pc_q + {{8{ir_q[7]}}, ir_q[7:0]}
                                                : pc_q + 16'd1;
`else
  assign next_pc = pc_q + 16'd1;
`endif

  // Fetch handshake: instr_req is high for every FETCH cycle with instr_addr
  // held at pc; the word transfers on the first edge where instr_ack is also
  // high. instr_ack in any other state is ignored.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    rdest_d  = rdest_q;
    rsrc_d   = rsrc_q;
    imm_d    = imm_q;
    imm_s_d  = imm_s_q;
    opcode_d = opcode_q;
    en_d     = 1'b0;
    halted_d = halted_q;
    case (state_q)
      ST_FETCH: begin
        if (instr_ack) begin
          ir_d    = instr_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        rdest_d  = dec.rdest;
        rsrc_d   = dec.rsrc;
        imm_d    = dec.imm;
        imm_s_d  = dec.imm_s;
        opcode_d = dec.opcode;
        en_d     = dec.en;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec.cap_flags) flags_d = Flags;
        pc_d = next_pc;
        if (dec.is_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= 16'h0000;
      pc_q     <= RESET_PC;
      flags_q  <= 5'b0;
      rdest_q  <= 4'h0;
      rsrc_q   <= 4'h0;
      imm_q    <= 16'h0000;
      imm_s_q  <= 1'b0;
      opcode_q <= 5'h00;
      en_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      rdest_q  <= rdest_d;
      rsrc_q   <= rsrc_d;
      imm_q    <= imm_d;
      imm_s_q  <= imm_s_d;
      opcode_q <= opcode_d;
      en_q     <= en_d;
      halted_q <= halted_d;
    end
  end

  assign instr_req   = (state_q == ST_FETCH);
  assign instr_addr  = pc_q;
  assign pc          = pc_q;
  assign RdestRegLoc = rdest_q;
  assign RsrcRegLoc  = rsrc_q;
  assign Imm         = imm_q;
  assign Imm_s       = imm_s_q;
  assign OpCode      = opcode_q;
  assign En          = en_q;
  assign halted      = halted_q;
  assign dbg_state   = state_q;
  assign dbg_flags   = flags_q;

endmodule
